// File: rtl/alu_op_sequencer.sv
// Control-step sequencer for the mini-CPU bus datapath: accepts one ALU command per
// start/ready handshake and walks the register/Y/Z/HI/LO strobes through fixed T-steps.
module alu_op_sequencer #(
  parameter logic [4:0] OP_NEG = 5'b01001,
  parameter logic [4:0] OP_NOT = 5'b01010,
  parameter logic [4:0] OP_MUL = 5'b01011,
  parameter logic [4:0] OP_DIV = 5'b01100
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op_in,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic        ready,
  output logic        done,
  output logic [4:0]  op,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        ZHighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TY   = 3'd1,
    S_TALU = 3'd2,
    S_TWHI = 3'd3,
    S_TWLO = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] op_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic       unary_in, wide_q;

  assign unary_in = (op_in == OP_NEG) || (op_in == OP_NOT);
  assign wide_q   = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? (unary_in ? S_TALU : S_TY) : S_IDLE;
      S_TY:    state_d = S_TALU;
      S_TALU:  state_d = wide_q ? S_TWHI : S_TWLO;
      S_TWHI:  state_d = S_TWLO;
      S_TWLO:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q <= op_in;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
    end
  end

  // Moore decode: every strobe is a function of the registered state and latched fields,
  // and illegal encodings fall to the all-zero default.
  always_comb begin
    ready    = 1'b0;
    done     = 1'b0;
    op       = '0;
    Rout     = '0;
    Rin      = '0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    ZHighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    case (state_q)
      S_IDLE: ready = 1'b1;
      S_TY: begin
        op   = op_q;
        Rout = 16'd1 << rb_q;
        Yin  = 1'b1;
      end
      S_TALU: begin
        op      = op_q;
        Rout    = 16'd1 << rc_q;
        Zlowin  = 1'b1;
        ZHighin = wide_q;
      end
      S_TWHI: begin
        op       = op_q;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_TWLO: begin
        op      = op_q;
        Zlowout = 1'b1;
        LOin    = wide_q;
        Rin     = wide_q ? 16'd0 : (16'd1 << ra_q);
      end
      S_DONE: begin
        op   = op_q;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a small datapath model reacts to the strobes,
// expected results are queued at issue time and checked by a monitor on each done pulse.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_NEG = 5'b01001;
  localparam logic [4:0] OP_NOT = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01011;
  localparam logic [4:0] OP_DIV = 5'b01100;

  logic        Clock, clear, start;
  logic [4:0]  op_in;
  logic [3:0]  ra, rb, rc;
  logic        ready, done;
  logic [4:0]  op;
  logic [15:0] Rout, Rin;
  logic        Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin;

  alu_op_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .op_in(op_in),
    .ra(ra), .rb(rb), .rc(rc), .ready(ready), .done(done), .op(op),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .Zlowin(Zlowin), .ZHighin(ZHighin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: register file, Y, Z, HI, LO driven purely by the strobes.
  logic [31:0] rf [16];
  logic [31:0] y_m, hi_m, lo_m;
  logic [63:0] z_m;
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  function automatic logic [63:0] alu(input logic [4:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
    case (o)
      OP_NEG:  alu = {32'd0, 32'd0 - b};
      OP_NOT:  alu = {32'd0, ~b};
      OP_MUL:  alu = 64'(a) * 64'(b);
      OP_DIV:  alu = (b != 0) ? {a % b, a / b} : 64'd0;
      default: alu = {32'd0, a + b};
    endcase
  endfunction

  always @(posedge Clock) begin : model
    logic [31:0] bus;
    logic [63:0] res;
    bus = '0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = rf[i];
    if (Zlowout)  bus = z_m[31:0];
    if (Zhighout) bus = z_m[63:32];
    res = alu(op, y_m, bus);
    if (Yin)     y_m <= bus;
    if (Zlowin)  z_m[31:0] <= res[31:0];
    if (ZHighin) z_m[63:32] <= res[63:32];
    for (int i = 0; i < 16; i++) if (Rin[i]) rf[i] <= bus;
    if (HIin) hi_m <= bus;
    if (LOin) lo_m <= bus;
    if (pre_en) rf[pre_idx] <= pre_val;
  end

  typedef struct {
    logic [4:0]  op;
    int          lat;
    bit          wide;
    bit          yin;
    logic [3:0]  dst;
    logic [31:0] val;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(input logic [4:0] o, input int lat, input bit wide,
                              input bit yin, input logic [3:0] dst, input logic [31:0] val,
                              input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.op = o; e.lat = lat; e.wide = wide; e.yin = yin;
    e.dst = dst; e.val = val; e.hi = hi; e.lo = lo;
    return e;
  endfunction

  // Monitor: per-cycle exclusivity, then per-command latency/strobe/result checks on done.
  bit busy = 0, yin_seen, op_bad;
  int cyc, hi_cyc, lo_cyc;

  always @(negedge Clock) begin
    exp_t e;
    checks++;
    if (!$onehot0(Rout) || !$onehot0(Rin) || !$onehot0({|Rout, Zlowout, Zhighout})) begin
      errors++;
      $display("FAIL exclusivity: Rout=%h Rin=%h Zlowout=%b Zhighout=%b required onehot0",
               Rout, Rin, Zlowout, Zhighout);
    end
    if (!clear) begin
      busy = 0;
    end else begin
      if (done && !busy) chk("spurious_done", 1, 0);
      if (busy) begin
        cyc++;
        if (Yin)  yin_seen = 1;
        if (HIin) hi_cyc = cyc;
        if (LOin) lo_cyc = cyc;
        if (q.size() > 0 && op !== q[0].op) op_bad = 1;
        if (done) begin
          busy = 0;
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", 64'(cyc), 64'(e.lat));
            chk("yin_seen", 64'(yin_seen), 64'(e.yin));
            chk("op_held", 64'(op_bad), 0);
            if (e.wide) begin
              chk("hi_value", 64'(hi_m), 64'(e.hi));
              chk("lo_value", 64'(lo_m), 64'(e.lo));
              chk("hi_before_lo", 64'(hi_cyc > 0 && hi_cyc < lo_cyc), 1);
            end else begin
              chk("dest_value", 64'(rf[e.dst]), 64'(e.val));
            end
          end
        end
      end
      if (ready && start) begin
        busy = 1; cyc = 0; yin_seen = 0; op_bad = 0; hi_cyc = -1; lo_cyc = -1;
      end
    end
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(posedge Clock); #1;
    pre_en = 1; pre_idx = idx; pre_val = val;
    @(posedge Clock); #1;
    pre_en = 0;
  endtask

  task automatic issue(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input exp_t e);
    int n = 0;
    q.push_back(e);
    op_in = o; ra = a; rb = b; rc = c; start = 1;
    do begin
      @(negedge Clock);
      n++;
    end while (!ready && n < 50);
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(posedge Clock); #1;
    start = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    @(posedge Clock); #1;
    chk("drain_timeout", 64'(q.size()), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready), 1);
    chk({tag, "_op"}, 64'(op), 0);
    chk({tag, "_strobes"},
        64'({done, Rout, Rin, Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin}), 0);
  endtask

  initial begin
    clear = 0; start = 0; op_in = '0; ra = '0; rb = '0; rc = '0;
    pre_en = 0; pre_idx = '0; pre_val = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk_idle_outputs("por");
    clear = 1;

    preload(4'd1, 32'd5);
    preload(4'd2, 32'd7);
    preload(4'd4, 32'h0001_0000);
    preload(4'd5, 32'h0001_0000);
    preload(4'd7, 32'd12);

    issue(OP_ADD, 4'd3, 4'd1, 4'd2, mk(OP_ADD, 4, 0, 1, 4'd3, 32'd12, 0, 0));
    drain();
    chk("y_after_ty", 64'(y_m), 64'd5);

    issue(OP_NEG, 4'd6, 4'd0, 4'd7, mk(OP_NEG, 3, 0, 0, 4'd6, 32'hFFFF_FFF4, 0, 0));
    drain();

    issue(OP_MUL, 4'd0, 4'd4, 4'd5, mk(OP_MUL, 5, 1, 1, 4'd0, 0, 32'd1, 32'd0));
    drain();

    issue(OP_DIV, 4'd0, 4'd3, 4'd2, mk(OP_DIV, 5, 1, 1, 4'd0, 0, 32'd5, 32'd1));
    drain();

    issue(OP_NOT, 4'd11, 4'd0, 4'd1, mk(OP_NOT, 3, 0, 0, 4'd11, 32'hFFFF_FFFA, 0, 0));
    drain();

    // Busy-time start pulse with another op must be dropped; a held start waits for IDLE.
    issue(OP_ADD, 4'd8, 4'd3, 4'd1, mk(OP_ADD, 4, 0, 1, 4'd8, 32'd17, 0, 0));
    op_in = OP_MUL; ra = 4'd15; rb = 4'd4; rc = 4'd5; start = 1;
    @(posedge Clock); #1;
    start = 0;
    issue(OP_NEG, 4'd9, 4'd0, 4'd8, mk(OP_NEG, 3, 0, 0, 4'd9, 32'hFFFF_FFEF, 0, 0));
    drain();
    chk("ignored_cmd_no_write", 64'(rf[15]), 0);

    issue(5'b11111, 4'd10, 4'd1, 4'd2, mk(5'b11111, 4, 0, 1, 4'd10, 32'd12, 0, 0));
    drain();

    issue(OP_ADD, 4'd1, 4'd1, 4'd2, mk(OP_ADD, 4, 0, 1, 4'd1, 32'd12, 0, 0));
    drain();

    // Abort an ADD while it sits in T_ALU.
    op_in = OP_ADD; ra = 4'd12; rb = 4'd1; rc = 4'd2;
    @(posedge Clock); #1;
    start = 1;
    @(posedge Clock); #1;
    start = 0;
    @(posedge Clock); #1;
    chk("pre_abort_t_alu", 64'(Zlowin), 1);
    clear = 0;
    #1;
    chk_idle_outputs("abort_async");
    repeat (2) @(posedge Clock);
    #1;
    chk_idle_outputs("abort_held");
    clear = 1;
    repeat (4) @(posedge Clock);
    #1;
    chk_idle_outputs("abort_after");
    chk("abort_no_write", 64'(rf[12]), 0);

    issue(OP_ADD, 4'd13, 4'd2, 4'd2, mk(OP_ADD, 4, 0, 1, 4'd13, 32'd14, 0, 0));
    drain();

    repeat (3) @(posedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
